// File: rtl/alien_bomb_if.sv
// ============================================================================
// alien_bomb_if : launch request, rocket position and pixel-request bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface alien_bomb_if;
  logic       fireReq;
  logic [7:0] fireX;
  logic [6:0] fireY;
  logic [7:0] rocketX;
  logic       fireAck;
  logic [7:0] bombX;
  logic [6:0] bombY;
  logic [2:0] colour;
  logic       drawEn;
  logic       hitPlayer;
  logic       busy;

  modport master (
    output fireReq, fireX, fireY, rocketX,
    input  fireAck, bombX, bombY, colour, drawEn, hitPlayer, busy
  );

  modport slave (
    input  fireReq, fireX, fireY, rocketX,
    output fireAck, bombX, bombY, colour, drawEn, hitPlayer, busy
  );
endinterface

`default_nettype wire

// File: rtl/alien_bomb.sv
// ============================================================================
// alien_bomb : single downward bomb stepping the playfield, draw/erase + hit
// Rev 1.0
// ============================================================================
`default_nettype none

module alien_bomb #(
  parameter int TICKS_PER_STEP = 12500000,
  parameter int STEP           = 4,
  parameter int ROCKET_Y       = 105,
  parameter int ROCKET_W       = 8,
  parameter int Y_BOTTOM       = 116
) (
  input  logic        clk,
  input  logic        reset,
  alien_bomb_if.slave bus
);

  localparam int CNT_W = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
  localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(TICKS_PER_STEP - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRAW  = 3'd1,
    S_WAIT  = 3'd2,
    S_ERASE = 3'd3,
    S_MOVE  = 3'd4,
    S_CHECK = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       bomb_x_q, bomb_x_d;
  logic [6:0]       bomb_y_q, bomb_y_d;
  logic             hit_q, hit_d;

  logic       w_fire_ack;
  logic [2:0] w_colour;
  logic       w_draw_en;
  logic       w_busy;

  logic [7:0] w_y_sum;
  logic [6:0] w_y_next;
  logic [8:0] w_x9;
  logic [8:0] w_rx9;
  logic [8:0] w_rx_end;
  logic       w_hit;
  logic       w_bottom;

  // Step sum is one bit wider than bombY so it can be clamped at the bottom edge
  assign w_y_sum  = {1'b0, bomb_y_q} + 8'(STEP);
  assign w_y_next = (w_y_sum > 8'd127) ? 7'd127 : w_y_sum[6:0];

  // 9-bit span so a rocket near the right edge does not wrap to x=0
  assign w_x9     = {1'b0, bomb_x_q};
  assign w_rx9    = {1'b0, bus.rocketX};
  assign w_rx_end = w_rx9 + 9'(ROCKET_W);
  assign w_hit    = (bomb_y_q >= 7'(ROCKET_Y)) && (w_x9 >= w_rx9) && (w_x9 < w_rx_end);
  assign w_bottom = (bomb_y_q >= 7'(Y_BOTTOM));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bomb_x_q <= '0;
      bomb_y_q <= '0;
      hit_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bomb_x_q <= bomb_x_d;
      bomb_y_q <= bomb_y_d;
      hit_q    <= hit_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bomb_x_d   = bomb_x_q;
    bomb_y_d   = bomb_y_q;
    hit_d      = 1'b0;
    w_fire_ack = 1'b0;
    w_colour   = 3'b000;
    w_draw_en  = 1'b0;
    w_busy     = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        w_busy = 1'b0;
        if (bus.fireReq) begin
          w_fire_ack = 1'b1;
          bomb_x_d   = bus.fireX;
          bomb_y_d   = bus.fireY;
          state_d    = S_DRAW;
        end
      end
      S_DRAW: begin
        w_draw_en = 1'b1;
        w_colour  = 3'b111;
        cnt_d     = C_CNT_LOAD;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_ERASE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_ERASE: begin
        w_draw_en = 1'b1;
        state_d   = S_MOVE;
      end
      S_MOVE: begin
        bomb_y_d = w_y_next;
        state_d  = S_CHECK;
      end
      S_CHECK: begin
        // A hit wins over reaching the bottom; both retire without a redraw
        if (w_hit) begin
          hit_d   = 1'b1;
          state_d = S_IDLE;
        end else if (w_bottom) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DRAW;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.fireAck   = w_fire_ack;
  assign bus.bombX     = bomb_x_q;
  assign bus.bombY     = bomb_y_q;
  assign bus.colour    = w_colour;
  assign bus.drawEn    = w_draw_en;
  assign bus.hitPlayer = hit_q;
  assign bus.busy      = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_alien_bomb.sv
// ============================================================================
// tb_alien_bomb : directed self-checking bench for alien_bomb (TICKS_PER_STEP=4)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_alien_bomb;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;

  alien_bomb_if bus();

  alien_bomb #(.TICKS_PER_STEP(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Presents a request in an IDLE cycle, checks the ack, leaves us in the DRAW cycle
  task automatic launch(input logic [7:0] x, input logic [6:0] y);
    bus.fireX   = x;
    bus.fireY   = y;
    bus.fireReq = 1'b1;
    #1;
    chk("launch_ack", 32'(bus.fireAck), 32'd1);
    tick();
    bus.fireReq = 1'b0;
  endtask

  initial begin
    int          cyc;
    int          ack_bad;
    int          hit_seen;
    logic [6:0]  last_y;

    bus.fireReq = 1'b0;
    bus.fireX   = '0;
    bus.fireY   = '0;
    bus.rocketX = '0;

    // Reset state
    #12;
    chk("reset_outputs", {bus.busy, bus.drawEn, bus.hitPlayer, bus.fireAck, bus.colour,
                          bus.bombX, bus.bombY}, 32'd0);
    reset = 1'b1;
    tick(2);
    chk("idle_after_release", 32'(bus.busy), 32'd0);

    // First step timing at (40,20), rocket at 46 never in reach
    bus.rocketX = 8'd46;
    launch(8'd40, 7'd20);
    chk("draw1_colour", {bus.drawEn, bus.colour}, 32'b1111);
    chk("draw1_xy", {bus.bombX, bus.bombY}, {8'd40, 7'd20});
    tick();
    chk("wait_quiet", {bus.busy, bus.drawEn}, 32'b10);
    tick(4);
    chk("erase1", {bus.drawEn, bus.colour, bus.bombY}, {1'b1, 3'b000, 7'd20});
    tick();
    chk("move_quiet", {bus.drawEn, bus.bombY}, {1'b0, 7'd20});
    tick(2);
    chk("draw2", {bus.drawEn, bus.colour, bus.bombY}, {1'b1, 3'b111, 7'd24});

    // Hold fireReq through the rest of the flight; bomb retires after y=116
    bus.fireX   = 8'd50;
    bus.fireY   = 7'd100;
    bus.fireReq = 1'b1;
    cyc = 0; ack_bad = 0; hit_seen = 0; last_y = '0;
    while (bus.busy && cyc < 400) begin
      if (bus.fireAck) ack_bad++;
      if (bus.hitPlayer) hit_seen++;
      if (bus.drawEn && bus.colour == 3'b111) last_y = bus.bombY;
      tick();
      cyc++;
    end
    chk("retire_cycles", 32'(cyc), 32'd184);
    chk("no_ack_while_busy", 32'(ack_bad), 32'd0);
    chk("no_hit_pulse_flight1", 32'(hit_seen), 32'd0);
    chk("last_draw_y", 32'(last_y), 32'd112);
    chk("retire_hold_y", 32'(bus.bombY), 32'd116);
    chk("ack_first_idle", 32'(bus.fireAck), 32'd1);

    // Hit: x=50 against rocket 46..53, reached at y=108
    tick();
    bus.fireReq = 1'b0;
    chk("hit_draw100", {bus.drawEn, bus.bombX, bus.bombY}, {1'b1, 8'd50, 7'd100});
    tick(8);
    chk("hit_draw104", {bus.drawEn, bus.colour, bus.bombY}, {1'b1, 3'b111, 7'd104});
    tick(7);
    chk("hit_check", {bus.busy, bus.drawEn, bus.hitPlayer, bus.bombY}, {3'b100, 7'd108});
    tick();
    chk("hit_pulse", {bus.busy, bus.drawEn, bus.hitPlayer}, 32'b001);
    tick();
    chk("hit_pulse_end", 32'(bus.hitPlayer), 32'd0);

    // Same flight, rocket moved away: retire at the bottom without a pulse
    bus.rocketX = 8'd60;
    launch(8'd50, 7'd100);
    tick(24);
    chk("miss_draw112", {bus.drawEn, bus.colour, bus.bombY}, {1'b1, 3'b111, 7'd112});
    tick(7);
    chk("miss_check116", {bus.busy, bus.bombY}, {1'b1, 7'd116});
    tick();
    chk("miss_retire", {bus.busy, bus.hitPlayer, bus.drawEn, bus.bombY}, {3'b000, 7'd116});

    // Right-edge rocket: x=3 must not match a wrapped span, x=254 must match
    bus.rocketX = 8'd252;
    launch(8'd3, 7'd104);
    tick(8);
    chk("wrap_no_hit", {bus.drawEn, bus.colour, bus.bombY}, {1'b1, 3'b111, 7'd108});
    tick(16);
    chk("wrap_retire", {bus.busy, bus.hitPlayer}, 32'b00);
    launch(8'd254, 7'd104);
    tick(8);
    chk("edge_hit", {bus.busy, bus.hitPlayer}, 32'b01);
    tick();

    // Launch below the bottom line: drawn once, erased, clamped at 127, retired
    bus.rocketX = 8'd0;
    launch(8'd100, 7'd125);
    chk("low_draw", {bus.drawEn, bus.colour, bus.bombY}, {1'b1, 3'b111, 7'd125});
    tick(5);
    chk("low_erase", {bus.drawEn, bus.colour}, 32'b1000);
    tick(2);
    chk("low_clamp", 32'(bus.bombY), 32'd127);
    tick();
    chk("low_retire", {bus.busy, bus.drawEn, bus.hitPlayer}, 32'b000);

    // Asynchronous reset in the middle of WAIT
    bus.rocketX = 8'd46;
    launch(8'd40, 7'd20);
    tick(2);
    #2 reset = 1'b0;
    #1;
    chk("async_reset", {bus.busy, bus.drawEn, bus.hitPlayer, bus.fireAck, bus.colour,
                        bus.bombX, bus.bombY}, 32'd0);
    #2 reset = 1'b1;
    tick(3);
    chk("stay_idle", {bus.busy, bus.bombY}, 32'd0);

    // Reset in a hit CHECK cycle cancels the pending pulse
    launch(8'd50, 7'd104);
    tick(7);
    chk("pend_check", {bus.busy, bus.hitPlayer, bus.bombY}, {2'b10, 7'd108});
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    chk("pend_cancel_in_reset", 32'(bus.hitPlayer), 32'd0);
    reset = 1'b1;
    tick();
    chk("pend_cancel_after", {bus.busy, bus.hitPlayer}, 32'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
